// File: rtl/test_harness_stream_tap_pkg.sv
// Shared definitions for the stream tap: FSM state encoding, default sync
// header value and a width helper used to size counters and pointers.
package test_harness_stream_tap_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_SYNC = 2'd1,
      ST_SEND = 2'd2
   } tap_state_e;

   localparam logic [7:0] DEFAULT_SYNC_PATTERN = 8'hA5;

   // Bits needed to index n items; never less than 1 so counters stay legal.
   function automatic int unsigned clog2_min1(input int unsigned n);
      int unsigned w;
      w = 1;
      while ((32'd1 << w) < n) begin
         w = w + 1;
      end
      return w;
   endfunction

endpackage

// File: rtl/test_harness_stream_tap_fifo.sv
// Capture FIFO for the stream tap.
// Ports:
//   CLK_1MHZ, RESET   clock, async active-low reset
//   push_i, wdata_i   write request and word (caller guarantees room, or a
//                     same-edge pop when full)
//   pop_i, rdata_o    read request and head word (rdata_o valid when !empty_o)
//   full_o, empty_o   occupancy flags
module test_harness_stream_tap_fifo
   import test_harness_stream_tap_pkg::*;
#(
   parameter int unsigned DATA_W = 48,
   parameter int unsigned DEPTH  = 4
) (
   input  logic              CLK_1MHZ,
   input  logic              RESET,
   input  logic              push_i,
   input  logic              pop_i,
   input  logic [DATA_W-1:0] wdata_i,
   output logic [DATA_W-1:0] rdata_o,
   output logic              full_o,
   output logic              empty_o
);

   localparam int unsigned AW = clog2_min1(DEPTH);
   localparam int unsigned CW = AW + 1;

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [AW-1:0]     wr_ptr_q;
   logic [AW-1:0]     rd_ptr_q;
   logic [CW-1:0]     count_q;

   // Pointers and occupancy; DEPTH is a power of two so pointers wrap naturally.
   always_ff @(posedge CLK_1MHZ or negedge RESET) begin
      if (!RESET) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push_i) wr_ptr_q <= wr_ptr_q + AW'(1);
         if (pop_i)  rd_ptr_q <= rd_ptr_q + AW'(1);
         case ({push_i, pop_i})
            2'b10:   count_q <= count_q + CW'(1);
            2'b01:   count_q <= count_q - CW'(1);
            default: count_q <= count_q;
         endcase
      end
   end

   // Storage; when full with a same-edge pop, the write lands in the slot
   // being vacated, whose old contents are read out before the edge.
   always_ff @(posedge CLK_1MHZ) begin
      if (push_i) mem_q[wr_ptr_q] <= wdata_i;
   end

   assign rdata_o = mem_q[rd_ptr_q];
   assign full_o  = (count_q == CW'(DEPTH));
   assign empty_o = (count_q == '0);

endmodule

// File: rtl/test_harness_stream_tap.sv
// Logic-analyzer tap: captures TEST_DATA on change (MODE=0) or continuously
// (MODE=1), queues captures, and replays each as a frame of LANE_W-bit
// chunks (optional sync header first, LSB chunk first).
// Ports:
//   CLK_1MHZ, RESET   clock, async active-low reset
//   TEST_DATA         tapped word
//   ENABLE            1 = captures allowed
//   MODE              0 = capture on change, 1 = free-run capture
//   D                 chunk output (0 between frames)
//   STROBE            first cycle of every chunk, sync included
//   FRAME             high for every cycle of a frame
//   OVERFLOW          sticky dropped-capture flag
//   DROP_CNT          saturating dropped-capture count
module test_harness_stream_tap
   import test_harness_stream_tap_pkg::*;
#(
   parameter int unsigned       DATA_W       = 48,
   parameter int unsigned       LANE_W       = 8,
   parameter int unsigned       DEPTH        = 4,
   parameter int unsigned       HOLD         = 1,
   parameter bit                SYNC_EN      = 1'b1,
   parameter logic [LANE_W-1:0] SYNC_PATTERN = LANE_W'(DEFAULT_SYNC_PATTERN)
) (
   input  logic              CLK_1MHZ,
   input  logic              RESET,
   input  logic [DATA_W-1:0] TEST_DATA,
   input  logic              ENABLE,
   input  logic              MODE,
   output logic [LANE_W-1:0] D,
   output logic              STROBE,
   output logic              FRAME,
   output logic              OVERFLOW,
   output logic [7:0]        DROP_CNT
);

   localparam int unsigned CHUNKS = (DATA_W + LANE_W - 1) / LANE_W;
   localparam int unsigned SH_W   = CHUNKS * LANE_W;
   localparam int unsigned HW     = clog2_min1(HOLD);
   localparam int unsigned IW     = clog2_min1(CHUNKS);

   tap_state_e        state_q, state_d;
   logic [HW-1:0]     hold_q, hold_d;
   logic [IW-1:0]     idx_q, idx_d;
   logic [SH_W-1:0]   shreg_q, shreg_d;
   logic [DATA_W-1:0] data_prev_q;

   logic [LANE_W-1:0] d_q, d_d;
   logic              strobe_q, strobe_d;
   logic              frame_q, frame_d;
   logic              ovf_q;
   logic [7:0]        drop_q;

   logic              fifo_push_c, fifo_pop_c;
   logic              fifo_full_c, fifo_empty_c;
   logic [DATA_W-1:0] fifo_rdata_c;
   logic              req_c, drop_c, hold_last_c;

   test_harness_stream_tap_fifo #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
   ) u_fifo (
      .CLK_1MHZ (CLK_1MHZ),
      .RESET    (RESET),
      .push_i   (fifo_push_c),
      .pop_i    (fifo_pop_c),
      .wdata_i  (TEST_DATA),
      .rdata_o  (fifo_rdata_c),
      .full_o   (fifo_full_c),
      .empty_o  (fifo_empty_c)
   );

   assign hold_last_c = (hold_q == HW'(HOLD - 1));

   // Frame sequencer; outputs are computed from the current state and
   // registered, so the IDLE pop cycle shows up as a one-cycle gap.
   always_comb begin
      state_d    = state_q;
      hold_d     = hold_q;
      idx_d      = idx_q;
      shreg_d    = shreg_q;
      d_d        = '0;
      strobe_d   = 1'b0;
      frame_d    = 1'b0;
      fifo_pop_c = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (!fifo_empty_c) begin
               fifo_pop_c = 1'b1;
               shreg_d    = SH_W'(fifo_rdata_c);
               idx_d      = '0;
               hold_d     = '0;
               state_d    = SYNC_EN ? ST_SYNC : ST_SEND;
            end
         end
         ST_SYNC: begin
            d_d      = SYNC_PATTERN;
            strobe_d = (hold_q == '0);
            frame_d  = 1'b1;
            if (hold_last_c) begin
               hold_d  = '0;
               state_d = ST_SEND;
            end else begin
               hold_d = hold_q + HW'(1);
            end
         end
         ST_SEND: begin
            d_d      = shreg_q[LANE_W-1:0];
            strobe_d = (hold_q == '0);
            frame_d  = 1'b1;
            if (hold_last_c) begin
               hold_d  = '0;
               shreg_d = shreg_q >> LANE_W;
               if (idx_q == IW'(CHUNKS - 1)) begin
                  state_d = ST_IDLE;
               end else begin
                  idx_d = idx_q + IW'(1);
               end
            end else begin
               hold_d = hold_q + HW'(1);
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Capture request and drop decision. Free-run keys off the sequencer's
   // next state so a new word is queued on the last frame cycle and the
   // following frame starts after a single idle cycle.
   always_comb begin
      if (MODE) begin
         req_c = ENABLE & fifo_empty_c & (state_d == ST_IDLE);
      end else begin
         req_c = ENABLE & (TEST_DATA != data_prev_q);
      end
      fifo_push_c = req_c & (~fifo_full_c | fifo_pop_c);
      drop_c      = req_c & ~fifo_push_c;
   end

   // State, counters and registered outputs.
   always_ff @(posedge CLK_1MHZ or negedge RESET) begin
      if (!RESET) begin
         state_q     <= ST_IDLE;
         hold_q      <= '0;
         idx_q       <= '0;
         shreg_q     <= '0;
         data_prev_q <= '0;
         d_q         <= '0;
         strobe_q    <= 1'b0;
         frame_q     <= 1'b0;
         ovf_q       <= 1'b0;
         drop_q      <= '0;
      end else begin
         state_q     <= state_d;
         hold_q      <= hold_d;
         idx_q       <= idx_d;
         shreg_q     <= shreg_d;
         data_prev_q <= TEST_DATA;
         d_q         <= d_d;
         strobe_q    <= strobe_d;
         frame_q     <= frame_d;
         if (drop_c) begin
            ovf_q <= 1'b1;
            if (drop_q != 8'hFF) drop_q <= drop_q + 8'd1;
         end
      end
   end

   assign D        = d_q;
   assign STROBE   = strobe_q;
   assign FRAME    = frame_q;
   assign OVERFLOW = ovf_q;
   assign DROP_CNT = drop_q;

endmodule

// File: tb/tb_test_harness_stream_tap.sv
// Bench for test_harness_stream_tap: three differently parameterised taps
// share one stimulus stream; a frame-level reference model predicts every
// output each cycle, plus directed scenarios with constant expectations.
module tb_test_harness_stream_tap;

   localparam int NI = 3;

   logic        CLK_1MHZ = 1'b0;
   logic        RESET;
   logic [47:0] td;
   logic        en;
   logic        mode;

   logic [7:0] d0, d1, d2, c0, c1, c2;
   logic       s0, s1, s2, f0, f1, f2, o0, o1, o2;

   // Instance configurations mirrored for the model.
   int         cfg_dw    [NI] = '{48, 20, 48};
   int         cfg_hold  [NI] = '{1, 3, 3};
   int         cfg_sync  [NI] = '{1, 0, 1};
   int         cfg_depth [NI] = '{4, 2, 4};
   logic [7:0] cfg_pat   [NI] = '{8'hA5, 8'hA5, 8'h3C};

   always #5 CLK_1MHZ = ~CLK_1MHZ;

   test_harness_stream_tap dut_a (
      .CLK_1MHZ (CLK_1MHZ), .RESET (RESET), .TEST_DATA (td),
      .ENABLE (en), .MODE (mode), .D (d0), .STROBE (s0), .FRAME (f0),
      .OVERFLOW (o0), .DROP_CNT (c0)
   );

   test_harness_stream_tap #(.DATA_W(20), .DEPTH(2), .HOLD(3), .SYNC_EN(1'b0)) dut_b (
      .CLK_1MHZ (CLK_1MHZ), .RESET (RESET), .TEST_DATA (td[19:0]),
      .ENABLE (en), .MODE (mode), .D (d1), .STROBE (s1), .FRAME (f1),
      .OVERFLOW (o1), .DROP_CNT (c1)
   );

   test_harness_stream_tap #(.HOLD(3), .SYNC_PATTERN(8'h3C)) dut_c (
      .CLK_1MHZ (CLK_1MHZ), .RESET (RESET), .TEST_DATA (td),
      .ENABLE (en), .MODE (mode), .D (d2), .STROBE (s2), .FRAME (f2),
      .OVERFLOW (o2), .DROP_CNT (c2)
   );

   logic [7:0] dv [NI];
   logic [7:0] cv [NI];
   logic       sv [NI];
   logic       fv [NI];
   logic       ov [NI];

   always_comb begin
      dv[0] = d0; dv[1] = d1; dv[2] = d2;
      sv[0] = s0; sv[1] = s1; sv[2] = s2;
      fv[0] = f0; fv[1] = f1; fv[2] = f2;
      ov[0] = o0; ov[1] = o1; ov[2] = o2;
      cv[0] = c0; cv[1] = c1; cv[2] = c2;
   end

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   // Queue of captured words, plus the frame currently being replayed
   // described by its remaining length and position.
   logic [63:0] m_mem  [NI][8];
   logic [63:0] m_cur  [NI];
   logic [63:0] m_prev [NI];
   int          m_head [NI];
   int          m_cnt  [NI];
   int          m_rem  [NI];
   int          m_pos  [NI];
   int          m_drops[NI];
   logic        m_ovf  [NI];
   logic [7:0]  e_d    [NI];
   logic        e_s    [NI];
   logic        e_f    [NI];

   task automatic model_reset();
      for (int i = 0; i < NI; i++) begin
         m_cur[i] = '0; m_prev[i] = '0; m_head[i] = 0; m_cnt[i] = 0;
         m_rem[i] = 0; m_pos[i] = 0; m_drops[i] = 0; m_ovf[i] = 1'b0;
         e_d[i] = '0; e_s[i] = 1'b0; e_f[i] = 1'b0;
      end
   endtask

   task automatic model_step(input int i);
      logic [63:0] tdi, mask, w;
      int chunks, flen, slot;
      bit idle_now, pop, next_idle, full, empty, req;
      mask      = (64'd1 << cfg_dw[i]) - 64'd1;
      tdi       = {16'd0, td} & mask;
      chunks    = (cfg_dw[i] + 7) / 8;
      flen      = (cfg_sync[i] + chunks) * cfg_hold[i];
      idle_now  = (m_rem[i] == 0);
      empty     = (m_cnt[i] == 0);
      full      = (m_cnt[i] == cfg_depth[i]);
      pop       = idle_now && !empty;
      next_idle = idle_now ? !pop : (m_rem[i] == 1);
      // Output after this edge reflects the frame position before it.
      if (m_rem[i] > 0) begin
         slot   = m_pos[i] / cfg_hold[i];
         e_s[i] = ((m_pos[i] % cfg_hold[i]) == 0);
         e_f[i] = 1'b1;
         if (cfg_sync[i] == 1 && slot == 0) begin
            e_d[i] = cfg_pat[i];
         end else begin
            w      = m_cur[i] >> (8 * (slot - cfg_sync[i]));
            e_d[i] = w[7:0];
         end
         m_pos[i]++;
         m_rem[i]--;
      end else begin
         e_d[i] = '0; e_s[i] = 1'b0; e_f[i] = 1'b0;
      end
      if (pop) begin
         m_cur[i]  = m_mem[i][m_head[i]];
         m_head[i] = (m_head[i] + 1) % cfg_depth[i];
         m_cnt[i]--;
         m_rem[i]  = flen;
         m_pos[i]  = 0;
      end
      req = en && (mode ? (empty && next_idle) : (tdi != m_prev[i]));
      if (req) begin
         if (!full || pop) begin
            m_mem[i][(m_head[i] + m_cnt[i]) % cfg_depth[i]] = tdi;
            m_cnt[i]++;
         end else begin
            m_ovf[i] = 1'b1;
            if (m_drops[i] < 255) m_drops[i]++;
         end
      end
      m_prev[i] = tdi;
   endtask

   always @(posedge CLK_1MHZ or negedge RESET) begin
      if (!RESET) model_reset();
      else for (int i = 0; i < NI; i++) model_step(i);
   end

   // ---------------- stimulus helpers ----------------
   task automatic check_all();
      for (int i = 0; i < NI; i++) begin
         check($sformatf("D[%0d]", i),        64'(dv[i]), 64'(e_d[i]));
         check($sformatf("STROBE[%0d]", i),   64'(sv[i]), 64'(e_s[i]));
         check($sformatf("FRAME[%0d]", i),    64'(fv[i]), 64'(e_f[i]));
         check($sformatf("OVERFLOW[%0d]", i), 64'(ov[i]), 64'(m_ovf[i]));
         check($sformatf("DROP_CNT[%0d]", i), 64'(cv[i]), 64'(m_drops[i]));
      end
   endtask

   task automatic tick();
      @(negedge CLK_1MHZ);
      check_all();
   endtask

   task automatic do_reset();
      RESET = 1'b0;
      td    = '0;
      en    = 1'b1;
      mode  = 1'b0;
      repeat (3) tick();
      RESET = 1'b1;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] seq_a [7];
      logic [7:0] seq_b [3];
      int ts [8];
      int nts, fcnt, scnt, rises, guard;
      logic pf;

      seq_a = '{8'hA5, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
      seq_b = '{8'hDE, 8'hBC, 8'h0A};

      RESET = 1'b0; td = '0; en = 1'b0; mode = 1'b0;
      #2;
      check("reset_D", 64'(d0), 64'd0);
      check("reset_FRAME", 64'(f0), 64'd0);
      do_reset();

      // Single word with sync header, LSB chunk first.
      td = 48'h060504030201;
      tick(); tick();
      for (int k = 0; k < 7; k++) begin
         tick();
         check($sformatf("seq_a_D%0d", k), 64'(d0), 64'(seq_a[k]));
         check("seq_a_STROBE", 64'(s0), 64'd1);
         check("seq_a_FRAME", 64'(f0), 64'd1);
      end
      tick();
      check("seq_a_end_D", 64'(d0), 64'd0);
      check("seq_a_end_FRAME", 64'(f0), 64'd0);

      // 20-bit word, no sync, HOLD=3 (dut_b); HOLD=3 with sync on dut_c.
      do_reset();
      td = 48'h0ABCDE;
      fcnt = 0; scnt = 0;
      for (int t = 1; t <= 30; t++) begin
         tick();
         if (t >= 3 && t <= 11) begin
            check($sformatf("seq_b_D%0d", t), 64'(d1), 64'(seq_b[(t - 3) / 3]));
            check("seq_b_STROBE", 64'(s1), 64'(((t - 3) % 3) == 0));
         end
         if (t == 12) check("seq_b_end_FRAME", 64'(f1), 64'd0);
         if (f2) fcnt++;
         if (s2) scnt++;
      end
      check("hold3_frame_len", 64'(fcnt), 64'd21);
      check("hold3_strobes", 64'(scnt), 64'd7);

      // Six changes on consecutive edges: FIFO of 4 fills, last is dropped.
      do_reset();
      for (int v = 1; v <= 6; v++) begin
         td = 48'(v);
         tick();
      end
      repeat (60) tick();
      check("burst_DROP_CNT", 64'(c0), 64'd1);
      check("burst_OVERFLOW", 64'(o0), 64'd1);
      repeat (10) tick();
      check("burst_OVERFLOW_sticky", 64'(o0), 64'd1);

      // Reset during chunk 3, TEST_DATA held afterwards.
      do_reset();
      td = 48'h665544332211;
      repeat (7) tick();
      check("pre_reset_chunk3", 64'(d0), 64'h44);
      #2 RESET = 1'b0;
      #1;
      check("async_reset_D", 64'(d0), 64'd0);
      check("async_reset_STROBE", 64'(s0), 64'd0);
      check("async_reset_FRAME", 64'(f0), 64'd0);
      tick(); tick();
      RESET = 1'b1;
      rises = 0; pf = f0;
      repeat (20) begin
         tick();
         if (f0 && !pf) rises++;
         pf = f0;
      end
      check("post_reset_frames", 64'(rises), 64'd1);

      // Free-run: back-to-back frames one idle cycle apart.
      do_reset();
      mode = 1'b1;
      td   = 48'h0000DEADBEEF;
      nts  = 0;
      for (int t = 0; t < 48; t++) begin
         tick();
         if (s0 && d0 == 8'hA5 && nts < 8) begin
            ts[nts] = t;
            nts++;
         end
      end
      check("freerun_frame_count_ge5", 64'(nts >= 5), 64'd1);
      for (int k = 1; k < nts; k++) begin
         check($sformatf("freerun_period%0d", k), 64'(ts[k] - ts[k - 1]), 64'd8);
      end
      guard = 0;
      while (!(f0 && d0 != 8'hA5) && guard < 16) begin
         tick();
         guard++;
      end
      check("freerun_midframe_found", 64'(guard < 16), 64'd1);
      en = 1'b0;
      guard = 0;
      while (f0 && guard < 16) begin
         tick();
         guard++;
      end
      check("freerun_frame_completes", 64'(guard < 16), 64'd1);
      rises = 0; pf = f0;
      repeat (30) begin
         tick();
         if (f0 && !pf) rises++;
         pf = f0;
      end
      check("disabled_no_frames", 64'(rises), 64'd0);
      check("freerun_DROP_CNT", 64'(c0), 64'd0);

      // Randomised traffic against the model.
      do_reset();
      for (int n = 0; n < 3000; n++) begin
         int r;
         r = $urandom_range(0, 999);
         if (r < 4) begin
            RESET = 1'b0;
            tick(); tick();
            RESET = 1'b1;
         end else begin
            if (r < 150)      td = 48'({$urandom(), $urandom()});
            else if (r < 220) td = 48'($urandom_range(0, 3));
            if (r >= 990) mode = ~mode;
            en = ($urandom_range(0, 9) != 0);
            tick();
         end
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
